// File: rtl/fibonacci_checker_if.sv
// Stream and status bundle for fibonacci_checker: the source drives in_valid/in_data,
// the checker drives the prediction, lock and error reporting back.
interface fibonacci_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  // in_valid qualifies in_data on every rising clk edge; there is no backpressure,
  // so a word presented with in_valid=1 is always consumed on that edge.
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] expected;
  logic             locked;
  logic             mismatch;
  logic             error_sticky;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_data,
    input  expected, locked, mismatch, error_sticky, match_count, err_count
  );

  modport slave (
    input  in_valid, in_data,
    output expected, locked, mismatch, error_sticky, match_count, err_count
  );
endinterface

// File: rtl/fibonacci_checker.sv
// Stream monitor checking that consecutive words follow x[n] = x[n-1] + x[n-2] mod 2^WIDTH.
// Reports lock, per-word mismatch pulses, a sticky error and saturating counters.
module fibonacci_checker #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_COUNT  = 3,
  parameter int STRICT_SEED = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  fibonacci_checker_if.slave  bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_TH = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, a_nxt;
  logic [WIDTH-1:0] b, b_nxt;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] match_q, match_nxt;
  logic [CNT_W-1:0] err_q;
  logic             bad;
  logic             mismatch_q;
  logic             sticky_q;

  // Carry is dropped by the WIDTH-bit result: the recurrence is mod 2^WIDTH.
  assign sum = a + b;

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    match_nxt = match_q;
    bad       = 1'b0;
    if (bus.in_valid) begin
      case (state)
        SEED0: begin
          if (STRICT_SEED != 0 && bus.in_data != '0) begin
            bad = 1'b1;
          end else begin
            a_nxt     = bus.in_data;
            state_nxt = SEED1;
          end
        end
        SEED1: begin
          if (STRICT_SEED != 0 && bus.in_data != WIDTH'(1)) begin
            bad       = 1'b1;
            state_nxt = SEED0;
          end else begin
            b_nxt     = bus.in_data;
            match_nxt = '0;
            state_nxt = TRACK;
          end
        end
        TRACK: begin
          if (bus.in_data == sum) begin
            a_nxt = b;
            b_nxt = bus.in_data;
            if (match_q != CNT_MAX) match_nxt = match_q + CNT_W'(1);
          end else begin
            bad       = 1'b1;
            match_nxt = '0;
            // Non-strict mode resynchronises: the rejected word seeds a new sequence.
            if (STRICT_SEED != 0) begin
              state_nxt = SEED0;
            end else begin
              a_nxt     = bus.in_data;
              state_nxt = SEED1;
            end
          end
        end
        default: state_nxt = SEED0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEED0;
      a          <= '0;
      b          <= '0;
      match_q    <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else if (clear) begin
      state      <= SEED0;
      a          <= '0;
      b          <= '0;
      match_q    <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      match_q    <= match_nxt;
      mismatch_q <= bad;
      if (bad) begin
        sticky_q <= 1'b1;
        if (err_q != CNT_MAX) err_q <= err_q + CNT_W'(1);
      end
    end
  end

  // Outputs depend only on registered state, never on the incoming word.
  assign bus.expected     = (state == TRACK) ? sum : '0;
  assign bus.locked       = (state == TRACK) && (match_q >= LOCK_TH);
  assign bus.mismatch     = mismatch_q;
  assign bus.error_sticky = sticky_q;
  assign bus.match_count  = match_q;
  assign bus.err_count    = err_q;
  assign state_dbg        = state;

endmodule

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
Stream monitor that consumes a word-per-beat sequence and checks that it obeys the Fibonacci recurrence modulo 2^WIDTH. Each term must equal (previous + one-before) mod 2^WIDTH.
Sits on the consumer side of a Fibonacci counter output, or any generalized-Fibonacci source, as a self-check and lock indicator.
Reports lock, per-word mismatch pulses, sticky error, and saturating match/error counters.

Parameters:
WIDTH, 4, data width; all sequence arithmetic is mod 2^WIDTH
CNT_W, 8, width of match_count and err_count
LOCK_COUNT, 3, consecutive matched terms required to assert locked (1..2^CNT_W-1)
STRICT_SEED, 0, 1 = the first two terms must be 0 then 1; 0 = any two words seed the sequence

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
clear  in  1  synchronous; re-arms the checker and clears counters and sticky error
in_valid  in  1  in_data is sampled on this edge
in_data  in  WIDTH  sequence term
expected  out  WIDTH  next predicted term; 0 when not in TRACK
locked  out  1  match_count >= LOCK_COUNT while in TRACK
mismatch  out  1  one-cycle pulse for a rejected word
error_sticky  out  1  set by any mismatch; cleared only by reset or clear
match_count  out  CNT_W  consecutive matches since the last seed; saturates at all-ones
err_count  out  CNT_W  total mismatches since reset or clear; saturates at all-ones

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state=SEED0, internal regs a=b=0, expected=0, locked=0, mismatch=0, error_sticky=0, match_count=0, err_count=0.
- All outputs are registered or derived only from registered state. There is no combinational path from in_* to any output.
- Consumption: a word is consumed on a rising edge with in_valid=1. Cycles with in_valid=0 change nothing, and mismatch is 0 in them.
- State SEED0, valid word:
  - a <= in_data, then go to SEED1.
  - If STRICT_SEED=1 and in_data!=0: mismatch, stay in SEED0, word discarded.
- State SEED1, valid word:
  - b <= in_data, match_count <= 0, then go to TRACK.
  - If STRICT_SEED=1 and in_data!=1: mismatch, go to SEED0.
- State TRACK: expected = (a+b) mod 2^WIDTH, with the carry discarded.
  - Valid word equal to expected: a <= b, b <= in_data, match_count increments (saturating), stay in TRACK.
  - Valid word not equal to expected: mismatch, match_count <= 0, locked <= 0.
    - If STRICT_SEED=0: go to SEED1 with a <= in_data (the bad word becomes the first seed of a new sequence).
    - If STRICT_SEED=1: go to SEED0 and discard the word.
- Effect of a mismatch, on the edge after the offending sample:
  - mismatch=1 for exactly one cycle.
  - error_sticky <= 1.
  - err_count increments, saturating.
  - Back-to-back bad words give back-to-back pulses, each one counted.
- locked:
  - Registered; asserts on the same edge that makes match_count reach LOCK_COUNT.
  - Deasserts on a mismatch, clear, or reset.
  - Never asserts in SEED0 or SEED1.
- Counter saturation: match_count and err_count hold at 2^CNT_W-1 and do not wrap. A saturated match_count keeps locked=1.
- clear=1 on an edge has the same effect as reset, applied synchronously.
- clear together with in_valid: clear wins and the word is discarded with no mismatch.
- Reset asserted mid-stream: immediate return to reset values. The first valid word after release is treated as the first seed.

Test Plan:
1. WIDTH=4, STRICT_SEED=0, LOCK_COUNT=3, feed 0,1,1,2,3,5,8,13,5,2,7 contiguously.
   Required: no mismatch; locked rises on the edge consuming the 5th word (value 3); final match_count=9; err_count=0; expected=9 at the end.
2. Wrap-around: seed 8,13, then feed 5,2,7,9,0,9.
   Required: all six words accepted, match_count=6, expected=9 after the last word.
3. Mismatch recovery: feed 0,1,1,2,4.
   - After 4: one-cycle mismatch, error_sticky=1, err_count=1, locked=0, state SEED1 with a=4.
   - Then feed 6,10,0: 6 becomes the seed, 10 matches, 0 matches ((6+10) mod 16); match_count=2.
4. STRICT_SEED=1, feed 1,0,2,0,1,1.
   - First 1: mismatch, stay in SEED0.
   - Then 0 seeds; 2 mismatches and returns to SEED0.
   - Then 0,1,1 gives TRACK with match_count=1.
   - Result: err_count=2.
5. Gaps and clear: sequence 0,1,1,2 with in_valid low for 3 cycles between words.
   - Required: identical results to the contiguous stream; expected holds during gaps.
   - Then clear with in_valid=1 and in_data=9: all counters 0, error_sticky=0, state SEED0, 9 discarded.
6. Saturation and reset: CNT_W=2, feed 0,1 then 5 valid matches. match_count must hold at 3 with locked=1. Then assert reset mid-word: all outputs return to their reset values immediately, without waiting for a clock edge.
